// File: rtl/multiplier_ppg9.sv
//==============================================================================
// Module      : multiplier_ppg9
// Description : Nine-lane signed 8x8 radix-4 Booth partial-product generator,
//               bits sorted into weight columns, registered outputs.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module multiplier_ppg9 (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] multiplicand9,
    input  logic [71:0] multiplier9,
    output logic [8:0]  O15,
    output logic [8:0]  O14,
    output logic [17:0] O13,
    output logic [17:0] O12,
    output logic [35:0] O11,
    output logic [35:0] O10,
    output logic [35:0] O9,
    output logic [35:0] O8,
    output logic [35:0] O7,
    output logic [44:0] O6,
    output logic [26:0] O5,
    output logic [35:0] O4,
    output logic [17:0] O3,
    output logic [26:0] O2,
    output logic [8:0]  O1,
    output logic [17:0] O0
);

    // Returns {neg, pp}; pp is already inverted for negative digits so the
    // +1 completing the two's complement travels separately as neg.
    function automatic logic [9:0] booth_pp(input logic [7:0] x, input logic [7:0] y, input int i);
        logic [8:0] y_ext;
        logic [2:0] trip;
        logic [8:0] mag;
        logic       neg;
        y_ext = {y, 1'b0};
        trip  = y_ext[2*i +: 3];
        mag   = '0;
        neg   = 1'b0;
        case (trip)
            3'b001, 3'b010: mag = {x[7], x};
            3'b011:         mag = {x, 1'b0};
            3'b100: begin
                mag = {x, 1'b0};
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                mag = {x[7], x};
                neg = 1'b1;
            end
            default: mag = '0;
        endcase
        return {neg, neg ? ~mag : mag};
    endfunction

    logic [8:0]  w_pp  [9][4];
    logic [3:0]  w_neg [9];
    logic [3:0]  w_s   [9];

    logic [17:0] w_o0;
    logic [8:0]  w_o1;
    logic [26:0] w_o2;
    logic [17:0] w_o3;
    logic [35:0] w_o4;
    logic [26:0] w_o5;
    logic [44:0] w_o6;
    logic [35:0] w_o7, w_o8, w_o9, w_o10, w_o11;
    logic [17:0] w_o12, w_o13;
    logic [8:0]  w_o14, w_o15;

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            for (int i = 0; i < 4; i++) begin
                {w_neg[k][i], w_pp[k][i]} = booth_pp(multiplicand9[8*k +: 8], multiplier9[8*k +: 8], i);
                w_s[k][i] = w_pp[k][i][8];
            end
        end
    end

    // Term j of column n for lane k lands at bit 9*j+k of On.
    always_comb begin
        w_o0 = '0; w_o1 = '0; w_o2 = '0; w_o3 = '0;
        w_o4 = '0; w_o5 = '0; w_o6 = '0; w_o7 = '0;
        w_o8 = '0; w_o9 = '0; w_o10 = '0; w_o11 = '0;
        w_o12 = '0; w_o13 = '0; w_o14 = '0; w_o15 = '0;
        for (int k = 0; k < 9; k++) begin
            w_o0[k]       = w_pp[k][0][0];
            w_o0[9+k]     = w_neg[k][0];
            w_o1[k]       = w_pp[k][0][1];
            w_o2[k]       = w_pp[k][0][2];
            w_o2[9+k]     = w_pp[k][1][0];
            w_o2[18+k]    = w_neg[k][1];
            w_o3[k]       = w_pp[k][0][3];
            w_o3[9+k]     = w_pp[k][1][1];
            w_o4[k]       = w_pp[k][0][4];
            w_o4[9+k]     = w_pp[k][1][2];
            w_o4[18+k]    = w_pp[k][2][0];
            w_o4[27+k]    = w_neg[k][2];
            w_o5[k]       = w_pp[k][0][5];
            w_o5[9+k]     = w_pp[k][1][3];
            w_o5[18+k]    = w_pp[k][2][1];
            w_o6[k]       = w_pp[k][0][6];
            w_o6[9+k]     = w_pp[k][1][4];
            w_o6[18+k]    = w_pp[k][2][2];
            w_o6[27+k]    = w_pp[k][3][0];
            w_o6[36+k]    = w_neg[k][3];
            w_o7[k]       = w_pp[k][0][7];
            w_o7[9+k]     = w_pp[k][1][5];
            w_o7[18+k]    = w_pp[k][2][3];
            w_o7[27+k]    = w_pp[k][3][1];
            w_o8[k]       = w_pp[k][0][8];
            w_o8[9+k]     = w_pp[k][1][6];
            w_o8[18+k]    = w_pp[k][2][4];
            w_o8[27+k]    = w_pp[k][3][2];
            w_o9[k]       = w_s[k][0];
            w_o9[9+k]     = w_pp[k][1][7];
            w_o9[18+k]    = w_pp[k][2][5];
            w_o9[27+k]    = w_pp[k][3][3];
            w_o10[k]      = w_s[k][0];
            w_o10[9+k]    = w_pp[k][1][8];
            w_o10[18+k]   = w_pp[k][2][6];
            w_o10[27+k]   = w_pp[k][3][4];
            w_o11[k]      = ~w_s[k][0];
            w_o11[9+k]    = ~w_s[k][1];
            w_o11[18+k]   = w_pp[k][2][7];
            w_o11[27+k]   = w_pp[k][3][5];
            w_o12[k]      = w_pp[k][2][8];
            w_o12[9+k]    = w_pp[k][3][6];
            w_o13[k]      = ~w_s[k][2];
            w_o13[9+k]    = w_pp[k][3][7];
            w_o14[k]      = w_pp[k][3][8];
            w_o15[k]      = ~w_s[k][3];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            O0 <= '0; O1 <= '0; O2 <= '0; O3 <= '0;
            O4 <= '0; O5 <= '0; O6 <= '0; O7 <= '0;
            O8 <= '0; O9 <= '0; O10 <= '0; O11 <= '0;
            O12 <= '0; O13 <= '0; O14 <= '0; O15 <= '0;
        end else begin
            O0 <= w_o0; O1 <= w_o1; O2 <= w_o2; O3 <= w_o3;
            O4 <= w_o4; O5 <= w_o5; O6 <= w_o6; O7 <= w_o7;
            O8 <= w_o8; O9 <= w_o9; O10 <= w_o10; O11 <= w_o11;
            O12 <= w_o12; O13 <= w_o13; O14 <= w_o14; O15 <= w_o15;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_multiplier_ppg9.sv
//==============================================================================
// Module      : tb_multiplier_ppg9
// Description : Scoreboard bench for multiplier_ppg9 (column sums rebuilt
//               into per-lane products and a nine-lane total).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_multiplier_ppg9;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [71:0] multiplicand9 = '0;
    logic [71:0] multiplier9 = '0;
    logic [8:0]  O15, O14, O1;
    logic [17:0] O13, O12, O3, O0;
    logic [35:0] O11, O10, O9, O8, O7, O4;
    logic [44:0] O6;
    logic [26:0] O5, O2;

    multiplier_ppg9 dut (
        .clk(clk), .reset(reset),
        .multiplicand9(multiplicand9), .multiplier9(multiplier9),
        .O15(O15), .O14(O14), .O13(O13), .O12(O12), .O11(O11), .O10(O10),
        .O9(O9), .O8(O8), .O7(O7), .O6(O6), .O5(O5), .O4(O4), .O3(O3),
        .O2(O2), .O1(O1), .O0(O0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [18:0]  sum;
        logic [143:0] prods;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic in_valid = 1'b0;
    logic out_valid = 1'b0;

    int c_terms [16] = '{2, 1, 3, 2, 4, 3, 5, 4, 4, 4, 4, 4, 2, 2, 1, 1};
    logic [44:0] o_arr [16];

    always_comb begin
        o_arr[0]  = 45'(O0);  o_arr[1]  = 45'(O1);  o_arr[2]  = 45'(O2);  o_arr[3]  = 45'(O3);
        o_arr[4]  = 45'(O4);  o_arr[5]  = 45'(O5);  o_arr[6]  = O6;       o_arr[7]  = 45'(O7);
        o_arr[8]  = 45'(O8);  o_arr[9]  = 45'(O9);  o_arr[10] = 45'(O10); o_arr[11] = 45'(O11);
        o_arr[12] = 45'(O12); o_arr[13] = 45'(O13); o_arr[14] = 45'(O14); o_arr[15] = 45'(O15);
    end

    function automatic logic [18:0] total_sum();
        logic [31:0] acc;
        acc = 32'h1D000;
        for (int n = 0; n < 16; n++)
            for (int j = 0; j < c_terms[n]; j++)
                for (int k = 0; k < 9; k++)
                    acc = acc + (32'(o_arr[n][9*j+k]) << n);
        return acc[18:0];
    endfunction

    function automatic logic [143:0] lane_prods();
        logic [31:0]  acc;
        logic [143:0] r;
        r = '0;
        for (int k = 0; k < 9; k++) begin
            acc = 32'h5000;
            for (int n = 0; n < 16; n++)
                for (int j = 0; j < c_terms[n]; j++)
                    acc = acc + (32'(o_arr[n][9*j+k]) << n);
            r[16*k +: 16] = acc[15:0];
        end
        return r;
    endfunction

    function automatic logic [413:0] all_outs();
        return {O15, O14, O13, O12, O11, O10, O9, O8, O7, O6, O5, O4, O3, O2, O1, O0};
    endfunction

    // Monitor: one result is due on the falling edge after each accepted input.
    always @(posedge clk) out_valid <= in_valid && !reset;

    always @(negedge clk) begin
        if (out_valid) begin
            exp_t        e;
            logic [18:0] got_s;
            logic [143:0] got_p;
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL sb_underflow: output present, no expected entry");
            end else begin
                e = q.pop_front();
                got_s = total_sum();
                got_p = lane_prods();
                n_tests++;
                if (got_s !== e.sum) begin
                    n_fail++;
                    $display("FAIL sum: got %0d expected %0d", $signed(got_s), $signed(e.sum));
                end
                n_tests++;
                if (got_p !== e.prods) begin
                    n_fail++;
                    $display("FAIL lanes: got %h expected %h", got_p, e.prods);
                end
            end
        end
    end

    function automatic logic [71:0] rep9(input logic [7:0] b);
        return {9{b}};
    endfunction

    task automatic issue(input logic [71:0] xv, input logic [71:0] yv,
                         input int exp_s, input logic [143:0] exp_p);
        exp_t e;
        @(posedge clk);
        #1;
        multiplicand9 = xv;
        multiplier9   = yv;
        e.sum   = 19'(exp_s);
        e.prods = exp_p;
        q.push_back(e);
        in_valid = 1'b1;
    endtask

    task automatic check_zero(input string name);
        n_tests++;
        if (all_outs() !== '0) begin
            n_fail++;
            $display("FAIL %s: outputs %h expected all zero", name, all_outs());
        end
    endtask

    initial begin
        #2 reset = 1'b1;
        #1 check_zero("reset_state");
        repeat (2) @(posedge clk);
        #1 check_zero("reset_hold");
        @(negedge clk);
        #1 reset = 1'b0;

        issue(rep9(8'h00), rep9(8'h00), 0,       {9{16'h0000}});
        issue(rep9(8'h80), rep9(8'h80), 147456,  {9{16'h4000}});
        issue(rep9(8'h7F), rep9(8'h80), -146304, {9{16'hC080}});
        issue(rep9(8'h80), rep9(8'h7F), -146304, {9{16'hC080}});
        issue(rep9(8'hFF), rep9(8'h01), -9,      {9{16'hFFFF}});
        issue(rep9(8'h4D), rep9(8'h00), 0,       {9{16'h0000}});
        issue(rep9(8'h00), rep9(8'h80), 0,       {9{16'h0000}});
        issue({8'h04, 8'h03, 8'h02, 8'h01, 8'h00, 8'hFF, 8'hFE, 8'hFD, 8'hFC},
              {8'hF3, 8'hF5, 8'hF7, 8'hF9, 8'hFB, 8'hFD, 8'hFF, 8'h01, 8'h03},
              -120,
              {16'hFFCC, 16'hFFDF, 16'hFFEE, 16'hFFF9, 16'h0000,
               16'h0003, 16'h0002, 16'hFFFD, 16'hFFF4});

        // Reset pulse while a vector is in flight: that vector is abandoned.
        issue(rep9(8'h05), rep9(8'hFD), -135, {9{16'hFFF1}});
        @(negedge clk);
        #1 reset = 1'b1;
        void'(q.pop_back());
        in_valid = 1'b0;
        #1 check_zero("reset_async");
        repeat (2) @(posedge clk);
        #1 check_zero("reset_midstream");
        begin
            exp_t e;
            multiplicand9 = rep9(8'h80);
            multiplier9   = rep9(8'h80);
            e.sum   = 19'(147456);
            e.prods = {9{16'h4000}};
            q.push_back(e);
            in_valid = 1'b1;
            #2 reset = 1'b0;
        end

        for (int xi = 0; xi < 256; xi++) begin
            for (int yi = 0; yi < 256; yi++) begin
                logic [7:0] xb, yb;
                int p;
                xb = 8'(xi);
                yb = 8'(yi);
                p  = int'($signed(xb)) * int'($signed(yb));
                issue(rep9(xb), rep9(yb), 9 * p, {9{16'(p)}});
            end
        end

        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 0; c < 5 && q.size() != 0; c++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
